// File: rtl/ks_subtract_serial.sv
// Byte-serial A-B via a radix-2 Kogge-Stone prefix network (A + ~B + 1).
// Optional macro KS_SUB_PIPE_EN registers every prefix level.
module ks_subtract_serial #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       borrow,
    output logic       zero,
    output logic       busy
);

    localparam int NBYTES = WIDTH / 8;
    localparam int LEVELS = $clog2(WIDTH);
    localparam int CW     = $clog2(2 * NBYTES);
    localparam int SW     = $clog2(LEVELS + 1);
`ifdef KS_SUB_PIPE_EN
    localparam int STAGE_LAST = LEVELS;
`else
    localparam int STAGE_LAST = 0;
`endif

    localparam logic [CW-1:0] NB_C      = CW'(NBYTES);
    localparam logic [CW-1:0] LAST_IN   = CW'(2 * NBYTES - 1);
    localparam logic [CW-1:0] LAST_OUT  = CW'(NBYTES - 1);
    localparam logic [SW-1:0] STAGE_END = SW'(STAGE_LAST);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        SEND
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    stage;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_sh;

    function automatic logic [WIDTH-1:0] lvl_g(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input int               s
    );
        logic [WIDTH-1:0] r;
        r = g;
        for (int i = s; i < WIDTH; i++) begin
            r[i] = g[i] | (p[i] & g[i-s]);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] lvl_p(
        input logic [WIDTH-1:0] p,
        input int               s
    );
        logic [WIDTH-1:0] r;
        r = p;
        for (int i = s; i < WIDTH; i++) begin
            r[i] = p[i] & p[i-s];
        end
        return r;
    endfunction

    // Bit-level propagate/generate of A + ~B; the carry-in of 1 is folded
    // into bit 0 so the prefix tree needs only log2(WIDTH) levels.
    logic [WIDTH-1:0] p_raw;
    logic [WIDTH-1:0] g_raw;
    logic [WIDTH-1:0] p_init;
    logic [WIDTH-1:0] g_init;

    assign p_raw  = a_reg ^ ~b_reg;
    assign g_raw  = a_reg & ~b_reg;
    assign g_init = g_raw | (p_raw & WIDTH'(1));
    assign p_init = p_raw & ~WIDTH'(1);

    logic [WIDTH-1:0] g_l [1:LEVELS];
    logic [WIDTH-1:0] p_l [1:LEVELS-1];

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        logic [WIDTH-1:0] gs;
        logic [WIDTH-1:0] ps;

        if (k == 0) begin : g_src0
            assign gs = g_init;
            assign ps = p_init;
        end else begin : g_srck
            assign gs = g_l[k];
            assign ps = p_l[k];
        end

`ifdef KS_SUB_PIPE_EN
        // Level register: group generate after span 2^k
        always_ff @(posedge clk) begin
            g_l[k+1] <= lvl_g(gs, ps, 1 << k);
        end
`else
        assign g_l[k+1] = lvl_g(gs, ps, 1 << k);
`endif

        if (k < LEVELS - 1) begin : g_prop
`ifdef KS_SUB_PIPE_EN
            // Level register: group propagate after span 2^k
            always_ff @(posedge clk) begin
                p_l[k+1] <= lvl_p(ps, 1 << k);
            end
`else
            assign p_l[k+1] = lvl_p(ps, 1 << k);
`endif
        end
    end

    // Carry into bit i is the group generate of bits [i-1:0] plus carry-in.
    logic [WIDTH-1:0] diff_c;
    logic             cout;

    assign diff_c = p_raw ^ {g_l[LEVELS][WIDTH-2:0], 1'b1};
    assign cout   = g_l[LEVELS][WIDTH-1];

    // Control FSM: load operands, wait for the tree, stream result bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            stage     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            diff_sh   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (cnt < NB_C) begin
                            a_reg <= (a_reg >> 8)
                                   | (WIDTH'(in_data) << (WIDTH - 8));
                        end else begin
                            b_reg <= (b_reg >> 8)
                                   | (WIDTH'(in_data) << (WIDTH - 8));
                        end
                        if (cnt == LAST_IN) begin
                            state    <= COMPUTE;
                            cnt      <= '0;
                            stage    <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (stage == STAGE_END) begin
                        diff_sh   <= diff_c;
                        out_data  <= diff_c[7:0];
                        borrow    <= ~cout;
                        zero      <= (diff_c == '0);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end else begin
                        stage <= stage + 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (cnt == LAST_OUT) begin
                            state     <= LOAD;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            diff_sh  <= diff_sh >> 8;
                            out_data <= 8'(diff_sh >> 8);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ks_subtract_serial.sv
// Randomised self-checking bench for ks_subtract_serial (WIDTH=16)
// against an arithmetic model of unsigned modular subtraction.
module tb_ks_subtract_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       borrow;
    logic       zero;
    logic       busy;

    int checks  = 0;
    int errors  = 0;
    int accepts = 0;

`ifdef KS_SUB_PIPE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 1;
`endif

    ks_subtract_serial #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .borrow   (borrow),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) accepts++;
    end

    // Reference: {borrow, zero, diff}
    function automatic logic [17:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] d;
        d = a - b;
        return {(a < b), (a == b), d};
    endfunction

    task automatic push_byte(input logic [7:0] d, output bit ok);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pull_byte(output logic [7:0] d, output logic b,
                             output logic z, output bit ok);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
        d  = out_data;
        b  = borrow;
        z  = zero;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                           input int gap, input int bp_max,
                           output logic [15:0] got, output logic bo,
                           output logic zo, output int lat,
                           output bit ok);
        bit          k;
        logic [7:0]  d;
        logic [31:0] bytes;
        ok    = 1'b1;
        bytes = {b, a};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            push_byte(bytes[8*i +: 8], k);
            ok &= k;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int j = 0; j < 2; j++) begin
            repeat ($urandom_range(0, bp_max)) @(negedge clk);
            pull_byte(d, bo, zo, k);
            ok &= k;
            got[8*j +: 8] = d;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid_busy got %b%b want 00", out_valid, busy);
        end
        checks++;
        if (out_data !== 8'h00 || borrow !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_data got %h %b %b want 00 0 0",
                     out_data, borrow, zero);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va [4] = '{16'h1234, 16'h0000, 16'h8000, 16'hBEEF};
        logic [15:0] vb [4] = '{16'h0034, 16'h0001, 16'h7FFF, 16'hBEEF};
        logic [15:0] got;
        logic [17:0] e;
        logic        bo, zo;
        int          lat;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            e = model(va[i], vb[i]);
            run_txn(va[i], vb[i], 0, 0, got, bo, zo, lat, ok);
            checks++;
            if (!ok || got !== e[15:0] || bo !== e[17] || zo !== e[16]) begin
                errors++;
                $display("FAIL vec%0d got %h b%b z%b ok%0d want %h b%b z%b",
                         i, got, bo, zo, ok, e[15:0], e[17], e[16]);
            end
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL vec%0d_latency got %0d want %0d", i, lat, LAT);
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_return got rdy%b vld%b want 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a = 16'hA5C3;
        logic [15:0] b = 16'h1234;
        logic [31:0] bytes;
        logic [17:0] e;
        logic [7:0]  d0, d1;
        logic        bo, zo;
        bit          ok, k;
        int          n;
        e     = model(a, b);
        bytes = {b, a};
        ok    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_byte(bytes[8*i +: 8], k);
            ok &= k;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e[7:0] ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got v%b d%h r%b y%b want 1 %h 0 1",
                         c, out_valid, out_data, in_ready, busy, e[7:0]);
            end
            @(negedge clk);
        end
        pull_byte(d0, bo, zo, k);
        ok &= k;
        pull_byte(d1, bo, zo, k);
        ok &= k;
        checks++;
        if (!ok || {d1, d0} !== e[15:0] || bo !== e[17]) begin
            errors++;
            $display("FAIL bp_result got %h%h b%b ok%0d want %h b%b",
                     d1, d0, bo, ok, e[15:0], e[17]);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] got;
        logic [17:0] e;
        logic        bo, zo;
        int          lat, a0;
        bit          ok;
        a0 = accepts;
        e  = model(16'hFFFF, 16'h0F0F);
        run_txn(16'hFFFF, 16'h0F0F, 2, 0, got, bo, zo, lat, ok);
        checks++;
        if (!ok || got !== e[15:0] || bo !== e[17] || zo !== e[16]) begin
            errors++;
            $display("FAIL gaps got %h b%b z%b want %h b%b z%b",
                     got, bo, zo, e[15:0], e[17], e[16]);
        end
        checks++;
        if (accepts - a0 != 4) begin
            errors++;
            $display("FAIL gaps_accepts got %0d want 4", accepts - a0);
        end
    endtask

    task automatic test_no_overlap();
        logic [31:0] bytes = {16'h0102, 16'h0304};
        logic [17:0] e;
        logic [7:0]  d0, d1;
        logic        bo, zo;
        bit          ok, k;
        int          n, a0;
        a0 = accepts;
        e  = model(16'h0304, 16'h0102);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_byte(bytes[8*i +: 8], k);
            ok &= k;
        end
        in_valid = 1'b1;
        in_data  = 8'h77;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        pull_byte(d0, bo, zo, k);
        ok &= k;
        pull_byte(d1, bo, zo, k);
        ok &= k;
        in_valid = 1'b0;
        checks++;
        if (!ok || {d1, d0} !== e[15:0] || accepts - a0 != 4) begin
            errors++;
            $display("FAIL no_overlap got %h%h acc%0d want %h acc4",
                     d1, d0, accepts - a0, e[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        logic [17:0] e;
        logic        bo, zo;
        int          lat;
        bit          ok, k;
        push_byte(8'h77, k);
        push_byte(8'h66, k);
        push_byte(8'h55, k);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got v%b y%b r%b want 000",
                     out_valid, busy, in_ready);
        end
        e = model(16'h0005, 16'h0003);
        run_txn(16'h0005, 16'h0003, 0, 0, got, bo, zo, lat, ok);
        checks++;
        if (!ok || got !== e[15:0] || bo !== e[17] || zo !== e[16]) begin
            errors++;
            $display("FAIL mid_rst_txn got %h b%b z%b want %h b%b z%b",
                     got, bo, zo, e[15:0], e[17], e[16]);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, got;
        logic [17:0] e;
        logic        bo, zo;
        int          lat;
        bit          ok;
        for (int t = 0; t < 24; t++) begin
            a = 16'($urandom);
            b = (t % 6 == 0) ? a : 16'($urandom);
            e = model(a, b);
            run_txn(a, b, $urandom_range(0, 2), 3, got, bo, zo, lat, ok);
            checks++;
            if (!ok || got !== e[15:0] || bo !== e[17] || zo !== e[16] ||
                lat != LAT) begin
                errors++;
                $display("FAIL rand%0d %h-%h got %h b%b z%b l%0d want %h b%b z%b l%0d",
                         t, a, b, got, bo, zo, lat,
                         e[15:0], e[17], e[16], LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_gaps();
        test_no_overlap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
